// File: rtl/snake_dir_decoder_pkg.sv
// rtl/snake_dir_decoder_pkg.sv - direction codes, scan codes and decode helpers
package snake_dir_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } key_state_e;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [7:0] SC_E0        = 8'hE0;
    localparam logic [7:0] SC_F0        = 8'hF0;
    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_UP_EXT    = 8'h75;
    localparam logic [7:0] SC_DOWN_EXT  = 8'h72;
    localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT_EXT = 8'h74;

    function automatic logic [2:0] dir_opposite(input logic [2:0] d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

    function automatic logic [2:0] decode_plain(input logic [7:0] b);
        case (b)
            SC_W:    return DIR_UP;
            SC_S:    return DIR_DOWN;
            SC_A:    return DIR_LEFT;
            SC_D:    return DIR_RIGHT;
            default: return DIR_NONE;
        endcase
    endfunction

    function automatic logic [2:0] decode_ext(input logic [7:0] b);
        case (b)
            SC_UP_EXT:    return DIR_UP;
            SC_DOWN_EXT:  return DIR_DOWN;
            SC_LEFT_EXT:  return DIR_LEFT;
            SC_RIGHT_EXT: return DIR_RIGHT;
            default:      return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/snake_dir_decoder_if.sv
// rtl/snake_dir_decoder_if.sv - scan-code byte handshake between PS/2 receiver and decoder
interface snake_dir_decoder_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ack;

    modport master (output data_in, output data_valid, input data_ack);
    modport slave  (input data_in, input data_valid, output data_ack);
endinterface

// File: rtl/snake_dir_decoder_ps2_key_fsm.sv
// rtl/snake_dir_decoder_ps2_key_fsm.sv - byte handshake and set-2 prefix FSM
module ps2_key_fsm
    import snake_dir_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ack,
    output logic [2:0] key_req,
    output logic       space_make
);

    key_state_e state_q, state_d;
    logic       wait_low_q, wait_low_d;
    logic       data_ack_q, data_ack_d;
    logic       accept;

    // wait_low blocks a second accept while the receiver still holds data_valid
    assign accept   = data_valid && !wait_low_q;
    assign data_ack = data_ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_low_q <= 1'b0;
            data_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_low_q <= wait_low_d;
            data_ack_q <= data_ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_low_d = wait_low_q;
        data_ack_d = accept;
        if (accept) begin
            wait_low_d = 1'b1;
        end else if (!data_valid) begin
            wait_low_d = 1'b0;
        end
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_in == SC_E0) begin
                        state_d = ST_EXT;
                    end else if (data_in == SC_F0) begin
                        state_d = ST_BRK;
                    end
                end
                ST_EXT: begin
                    if (data_in == SC_F0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Requests are combinational so pending/pause update on the accept edge itself
    always_comb begin
        key_req    = DIR_NONE;
        space_make = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    key_req    = decode_plain(data_in);
                    space_make = (data_in == SC_SPACE);
                end
                ST_EXT:  key_req = decode_ext(data_in);
                default: key_req = DIR_NONE;
            endcase
        end
    end

endmodule

// File: rtl/snake_dir_decoder.sv
// rtl/snake_dir_decoder.sv - pending direction buffer, pause toggle and per-tick commit
module snake_dir_decoder
    import snake_dir_decoder_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    snake_dir_decoder_if.slave         rx,
    input  logic                       move_tick,
    output logic [2:0]                 direction,
    output logic                       dir_changed,
    output logic                       pause
);

    logic [2:0] key_req;
    logic       space_make;
    logic       ack_w;

    logic [2:0] pending_q, pending_d;
    logic [2:0] direction_q, direction_d;
    logic       pause_q, pause_d;
    logic       dir_changed_q, dir_changed_d;
    logic       tick_ok;

    ps2_key_fsm u_key_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (rx.data_in),
        .data_valid (rx.data_valid),
        .data_ack   (ack_w),
        .key_req    (key_req),
        .space_make (space_make)
    );

    assign rx.data_ack = ack_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= DIR_NONE;
            direction_q   <= DIR_RIGHT;
            pause_q       <= 1'b0;
            dir_changed_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            direction_q   <= direction_d;
            pause_q       <= pause_d;
            dir_changed_q <= dir_changed_d;
        end
    end

    // Tick sees the old pause; a same-edge request overrides the tick's clear
    assign tick_ok = move_tick && !pause_q;

    always_comb begin
        pending_d     = pending_q;
        direction_d   = direction_q;
        dir_changed_d = 1'b0;
        pause_d       = pause_q ^ space_make;
        if (tick_ok) begin
            pending_d = DIR_NONE;
            if ((pending_q != DIR_NONE) && (pending_q != direction_q) &&
                (pending_q != dir_opposite(direction_q))) begin
                direction_d   = pending_q;
                dir_changed_d = 1'b1;
            end
        end
        if (key_req != DIR_NONE) begin
            pending_d = key_req;
        end
    end

    assign direction   = direction_q;
    assign dir_changed = dir_changed_q;
    assign pause       = pause_q;

endmodule
